sha256_round_ctrl: RTL and testbench



---
 rtl/sha256_round_ctrl.sv | 118 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 block: IV/digest keep, working-variable load,
// 64 rounds with message-word stalling, final hash update. Enables only, no data.
module sha256_round_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             first_block,
  input  logic             msg_valid,
  output logic             busy,
  output logic             hash_init,
  output logic             wv_load,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             w_sel_msg,
  output logic             msg_rd,
  output logic             hash_upd,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]   MSG_LIM  = (IDX_W + 1)'(MSG_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    busy      = 1'b0;
    hash_init = 1'b0;
    wv_load   = 1'b0;
    round_en  = 1'b0;
    round_idx = '0;
    w_sel_msg = 1'b0;
    msg_rd    = 1'b0;
    hash_upd  = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          first_d = first_block;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        busy      = 1'b1;
        hash_init = first_q;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        wv_load = 1'b1;
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        busy      = 1'b1;
        round_idx = cnt_q;
        w_sel_msg = ({1'b0, cnt_q} < MSG_LIM);
        // Only message-fed rounds wait on msg_valid; schedule rounds never stall.
        if (!w_sel_msg || msg_valid) begin
          round_en = 1'b1;
          msg_rd   = w_sel_msg;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_FINAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FINAL: begin
        busy     = 1'b1;
        hash_upd = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: table of block scenarios checked cycle
// by cycle against a timeline model, plus hand sequences for reset corner cases.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, first_block, msg_valid;
  logic       busy, hash_init, wv_load, round_en, w_sel_msg, msg_rd, hash_upd, done;
  logic [5:0] round_idx;
  logic [13:0] outvec;

  int n_checks = 0;
  int n_err    = 0;

  sha256_round_ctrl #(.ROUNDS(64), .MSG_WORDS(16), .IDX_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_block(first_block),
    .msg_valid  (msg_valid),
    .busy       (busy),
    .hash_init  (hash_init),
    .wv_load    (wv_load),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .w_sel_msg  (w_sel_msg),
    .msg_rd     (msg_rd),
    .hash_upd   (hash_upd),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign outvec = {busy, hash_init, wv_load, round_en, w_sel_msg, msg_rd,
                   hash_upd, done, round_idx};

  typedef enum {P_INIT, P_LOAD, P_ROUND, P_FINAL, P_DONE} phase_t;

  typedef struct {
    logic fb;
    int   stall_idx;
    int   stall_len;
    logic late_invalid;
    logic pulse_start;
    int   exp_done;
    int   exp_init;
    int   exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge, in an IDLE cycle.
  task automatic run_block(input vec_t v, input int id);
    phase_t      ph;
    int          r, stall_left, n_rd, n_init, done_at;
    logic        mv, stall, ren, wsel;
    logic [13:0] exp;
    start = 1'b1; first_block = v.fb; msg_valid = 1'b1;
    @(negedge clk);
    check($sformatf("blk%0d_idle_before", id), outvec, 14'h0);
    @(posedge clk); #1;
    start = 1'b0; first_block = ~v.fb;
    ph = P_INIT; r = 0; stall_left = v.stall_len;
    n_rd = 0; n_init = 0; done_at = -1;
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      mv = 1'b1;
      if (ph == P_ROUND && r == v.stall_idx && stall_left > 0) mv = 1'b0;
      if (ph == P_ROUND && r >= 16 && v.late_invalid) mv = 1'b0;
      msg_valid = mv;
      start = v.pulse_start && ph == P_ROUND && r == 20;
      wsel  = (ph == P_ROUND) && (r < 16);
      stall = wsel && !mv;
      ren   = (ph == P_ROUND) && !stall;
      exp = {1'b1, (ph == P_INIT) && v.fb, ph == P_LOAD, ren, wsel, ren && wsel,
             ph == P_FINAL, ph == P_DONE, (ph == P_ROUND) ? 6'(r) : 6'd0};
      @(negedge clk);
      check($sformatf("blk%0d_cyc%0d", id, c), outvec, exp);
      if (msg_rd) n_rd++;
      if (hash_init) n_init++;
      if (done) done_at = c;
      case (ph)
        P_INIT:  ph = P_LOAD;
        P_LOAD:  begin ph = P_ROUND; r = 0; end
        P_ROUND: begin
          if (stall) stall_left--;
          else if (r == 63) ph = P_FINAL;
          else r++;
        end
        P_FINAL: ph = P_DONE;
        default: ph = P_DONE;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0; msg_valid = 1'b0;
    check($sformatf("blk%0d_done_cycle", id), done_at, v.exp_done);
    check($sformatf("blk%0d_msg_rd_count", id), n_rd, v.exp_rd);
    check($sformatf("blk%0d_hash_init_count", id), n_init, v.exp_init);
  endtask

  initial begin
    //          fb    stall_idx len late  pulse done init rd
    vecs[0] = '{1'b1, -1,       0,  1'b0, 1'b0, 68,  1,   16};
    vecs[1] = '{1'b0, -1,       0,  1'b0, 1'b0, 68,  0,   16};
    vecs[2] = '{1'b1,  5,       3,  1'b0, 1'b0, 71,  1,   16};
    vecs[3] = '{1'b0, -1,       0,  1'b1, 1'b0, 68,  0,   16};
    vecs[4] = '{1'b1, -1,       0,  1'b0, 1'b1, 68,  1,   16};
    vecs[5] = '{1'b0, -1,       0,  1'b0, 1'b0, 68,  0,   16};
    vecs[6] = '{1'b1,  0,       2,  1'b0, 1'b0, 70,  1,   16};
    vecs[7] = '{1'b1, 15,       1,  1'b0, 1'b0, 69,  1,   16};

    reset = 1'b1; start = 1'b0; first_block = 1'b0; msg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", outvec, 14'h0);

    // reset beats start in the same cycle
    start = 1'b1; first_block = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_over_start", outvec, 14'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_no_start", outvec, 14'h0);
    @(posedge clk); #1;

    // entries run back to back: each start lands in the IDLE cycle after done
    for (int i = 0; i < 8; i++) run_block(vecs[i], i);

    // abort mid-ROUND at round_idx 40
    start = 1'b1; first_block = 1'b1; msg_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (round_en && round_idx == 6'd40) break;
      @(posedge clk); #1;
    end
    check("reach_idx40", round_idx, 32'd40);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; msg_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", outvec, 14'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("abort_quiet%0d", k), outvec, 14'h0);
    end
    @(posedge clk); #1;
    run_block(vecs[0], 8);

    // abort during a stall, then a first_block=0 block must not load the IV
    start = 1'b1; first_block = 1'b1; msg_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_hold_idx0", {round_en, round_idx}, 7'h0);
    check("stall_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_stall_idle", outvec, 14'h0);
    @(posedge clk); #1;
    run_block(vecs[1], 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
